// File: rtl/led_cmd_pkg.sv
// Shared constants, error codes and decoder states for the LED command decoder.
// LED_CMD_CHECKSUM_EN adds the trailing CHK byte and its GET_CHK state.
package led_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_FILL  = 8'h02;
    localparam logic [7:0] CMD_CLEAR = 8'h03;

    typedef enum logic [2:0] {
        ErrNone    = 3'd0,
        ErrBadChk  = 3'd1,
        ErrBadCmd  = 3'd2,
        ErrBadIdx  = 3'd3,
        ErrTimeout = 3'd4,
        ErrOverrun = 3'd5
    } err_code_e;

    typedef enum logic [3:0] {
        StIdle,
        StGetCmd,
        StGetIdx,
        StGetR,
        StGetG,
        StGetB,
`ifdef LED_CMD_CHECKSUM_EN
        StGetChk,
`endif
        StSweep
    } state_e;

endpackage

// File: rtl/led_sweep_gen.sv
// Address sweep 0..NUM_LEDS-1 for FILL/CLEAR; busy rises the cycle after start,
// done marks the last address.
module led_sweep_gen
    import led_cmd_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 16,
    parameter int unsigned IDX_W    = $clog2(NUM_LEDS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] addr
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_LEDS - 1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            busy <= 1'b0;
            addr <= '0;
        end else if (start) begin
            busy <= 1'b1;
            addr <= '0;
        end else if (busy) begin
            if (addr == LAST) begin
                busy <= 1'b0;
            end else begin
                addr <= addr + IDX_W'(1);
            end
        end
    end

    assign done = busy && (addr == LAST);

endmodule

// File: rtl/led_cmd_decoder.sv
// Frames SYNC/CMD/IDX/R/G/B[/CHK] byte commands into LED buffer writes and error reports.
// Define LED_CMD_CHECKSUM_EN for the 7-byte frame with checksum verification.
module led_cmd_decoder
    import led_cmd_pkg::*;
#(
    parameter int unsigned NUM_LEDS    = 16,
    parameter int unsigned IDX_W       = $clog2(NUM_LEDS),
    parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    output logic             o_wr_en,
    output logic [IDX_W-1:0] o_wr_addr,
    output logic [23:0]      o_wr_rgb,
    output logic             o_busy,
    output logic             o_frame_ok,
    output logic             o_err,
    output logic [2:0]       o_err_code,
    output logic [7:0]       o_err_cnt
);

`ifdef LED_CMD_CHECKSUM_EN
    localparam state_e LAST_ST = StGetChk;
    logic [7:0] blu;
`else
    localparam state_e LAST_ST = StGetB;
`endif

    state_e           state;
    logic [7:0]       cmd, idx, red, grn;
    logic [23:0]      idle_cnt;
    logic             wr_pulse;
    logic [IDX_W-1:0] wr_addr;
    logic [23:0]      wr_rgb;
    logic             frame_ok, err;
    err_code_e        err_code;
    logic [7:0]       err_cnt;

    logic             sweep_start, sweep_busy, sweep_done;
    logic [IDX_W-1:0] sweep_addr;

    logic             in_get, fin, chk_bad, cmd_bad, idx_bad, err_set, accept;
    logic [7:0]       fin_b;
    err_code_e        err_nxt;

    always_comb begin
        in_get = (state != StIdle) && (state != StSweep);
        fin    = i_rx_valid && (state == LAST_ST);
`ifdef LED_CMD_CHECKSUM_EN
        fin_b   = blu;
        chk_bad = (cmd ^ idx ^ red ^ grn ^ blu) != i_rx_data;
`else
        fin_b   = i_rx_data;
        chk_bad = 1'b0;
`endif
        cmd_bad = !(cmd inside {CMD_WRITE, CMD_FILL, CMD_CLEAR});
        idx_bad = (cmd == CMD_WRITE) && ({24'd0, idx} >= NUM_LEDS);

        err_nxt = ErrNone;
        if (in_get && !i_rx_valid && (idle_cnt == TIMEOUT_CYC - 24'd1)) begin
            err_nxt = ErrTimeout;
        end else if (i_rx_valid && (state == StSweep)) begin
            err_nxt = ErrOverrun;
        end else if (fin) begin
            if (chk_bad)      err_nxt = ErrBadChk;
            else if (cmd_bad) err_nxt = ErrBadCmd;
            else if (idx_bad) err_nxt = ErrBadIdx;
        end
        err_set     = (err_nxt != ErrNone);
        accept      = fin && !err_set;
        sweep_start = accept && (cmd != CMD_WRITE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= StIdle;
            cmd      <= '0;
            idx      <= '0;
            red      <= '0;
            grn      <= '0;
`ifdef LED_CMD_CHECKSUM_EN
            blu      <= '0;
`endif
            idle_cnt <= '0;
            wr_pulse <= 1'b0;
            wr_addr  <= '0;
            wr_rgb   <= '0;
            frame_ok <= 1'b0;
            err      <= 1'b0;
            err_code <= ErrNone;
            err_cnt  <= '0;
        end else begin
            wr_pulse <= 1'b0;
            frame_ok <= accept;
            err      <= err_set;
            if (err_set) begin
                err_code <= err_nxt;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end

            // Timeout counter only runs while a frame is partially received.
            if (in_get && !i_rx_valid && (err_nxt != ErrTimeout)) idle_cnt <= idle_cnt + 24'd1;
            else idle_cnt <= '0;

            if (sweep_busy) wr_addr <= sweep_addr;

            if (err_nxt == ErrTimeout) begin
                state <= StIdle;
            end else if (i_rx_valid) begin
                case (state)
                    StIdle:   if (i_rx_data == SYNC_BYTE) state <= StGetCmd;
                    StGetCmd: begin cmd <= i_rx_data; state <= StGetIdx; end
                    StGetIdx: begin idx <= i_rx_data; state <= StGetR;   end
                    StGetR:   begin red <= i_rx_data; state <= StGetG;   end
                    StGetG:   begin grn <= i_rx_data; state <= StGetB;   end
`ifdef LED_CMD_CHECKSUM_EN
                    StGetB:   begin blu <= i_rx_data; state <= StGetChk; end
                    StGetChk: state <= sweep_start ? StSweep : StIdle;
`else
                    StGetB:   state <= sweep_start ? StSweep : StIdle;
`endif
                    StSweep:  ;
                    default:  state <= StIdle;
                endcase
            end

            if ((state == StSweep) && sweep_done) state <= StIdle;

            if (accept) begin
                if (cmd == CMD_WRITE) begin
                    wr_pulse <= 1'b1;
                    wr_addr  <= idx[IDX_W-1:0];
                    wr_rgb   <= {red, grn, fin_b};
                end else begin
                    wr_rgb <= (cmd == CMD_FILL) ? {red, grn, fin_b} : 24'd0;
                end
            end
        end
    end

    led_sweep_gen #(
        .NUM_LEDS (NUM_LEDS),
        .IDX_W    (IDX_W)
    ) u_sweep (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .start   (sweep_start),
        .busy    (sweep_busy),
        .done    (sweep_done),
        .addr    (sweep_addr)
    );

    assign o_wr_en    = wr_pulse | sweep_busy;
    assign o_wr_addr  = sweep_busy ? sweep_addr : wr_addr;
    assign o_wr_rgb   = wr_rgb;
    assign o_busy     = sweep_busy;
    assign o_frame_ok = frame_ok;
    assign o_err      = err;
    assign o_err_code = err_code;
    assign o_err_cnt  = err_cnt;

endmodule

// File: tb/tb_led_cmd_decoder.sv
// Bench for led_cmd_decoder: directed frames plus random frames against an LED-buffer model.
module tb_led_cmd_decoder;

    localparam int unsigned N  = 16;
    localparam int unsigned AW = $clog2(N);
    localparam logic [23:0] TO = 24'd40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          wr_en, busy, frame_ok, err;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_rgb;
    logic [2:0]    err_code;
    logic [7:0]    err_cnt;

    led_cmd_decoder #(
        .NUM_LEDS    (N),
        .IDX_W       (AW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_wr_en    (wr_en),
        .o_wr_addr  (wr_addr),
        .o_wr_rgb   (wr_rgb),
        .o_busy     (busy),
        .o_frame_ok (frame_ok),
        .o_err      (err),
        .o_err_code (err_code),
        .o_err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed LED buffer and event counts, captured mid-cycle.
    logic [23:0] dut_mem [N] = '{default: 24'd0};
    int n_wr  = 0;
    int n_err = 0;
    int n_ok  = 0;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            dut_mem[wr_addr] = wr_rgb;
            n_wr++;
        end
        if (err === 1'b1) n_err++;
        if (frame_ok === 1'b1) n_ok++;
    end

    // Reference model: LED buffer contents and saturating error count.
    logic [23:0] ref_mem [N] = '{default: 24'd0};
    int          ref_cnt = 0;
    logic [7:0]  frame[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic build(input logic [7:0] cmd, input logic [7:0] idx, input logic [7:0] r,
                         input logic [7:0] g, input logic [7:0] b, input logic [7:0] flip);
        frame = {};
        frame.push_back(8'hA5);
        frame.push_back(cmd);
        frame.push_back(idx);
        frame.push_back(r);
        frame.push_back(g);
        frame.push_back(b);
`ifdef LED_CMD_CHECKSUM_EN
        frame.push_back(cmd ^ idx ^ r ^ g ^ b ^ flip);
`endif
    endtask

    task automatic send_frame();
        foreach (frame[i]) send_byte(frame[i]);
    endtask

    function automatic int ref_code(input int cmd, input int idx, input int flip);
`ifdef LED_CMD_CHECKSUM_EN
        if (flip != 0) return 1;
`endif
        if (cmd < 1 || cmd > 3) return 2;
        if (cmd == 1 && idx >= int'(N)) return 3;
        return 0;
    endfunction

    task automatic ref_err();
        if (ref_cnt < 255) ref_cnt++;
    endtask

    task automatic ref_apply(input int cmd, input int idx, input logic [23:0] rgb);
        for (int i = 0; i < int'(N); i++) begin
            if (cmd == 2) ref_mem[i] = rgb;
            if (cmd == 3) ref_mem[i] = 24'd0;
        end
        if (cmd == 1) ref_mem[idx] = rgb;
    endtask

    task automatic mem_check(input string tag);
        int bad = 0;
        for (int i = 0; i < int'(N); i++) if (dut_mem[i] !== ref_mem[i]) bad++;
        check({tag, "/mem"}, 32'(bad), 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < int'(N) + 4 && busy === 1'b1; i++) tick();
        check({tag, "/idle"}, 32'(busy), 32'd0);
        tick();
    endtask

    task automatic run_and_check(input string tag, input logic [7:0] cmd, input logic [7:0] idx,
                                 input logic [23:0] rgb, input logic [7:0] flip);
        int w0 = n_wr;
        int e0 = n_err;
        int k0 = n_ok;
        int code = ref_code(int'(cmd), int'(idx), int'(flip));
        int exp_wr = (code != 0) ? 0 : ((cmd == 8'h01) ? 1 : int'(N));
        build(cmd, idx, rgb[23:16], rgb[15:8], rgb[7:0], flip);
        send_frame();
        check({tag, "/err"}, 32'(err), 32'(code != 0));
        check({tag, "/wr_en"}, 32'(wr_en), 32'(code == 0));
        if (code != 0) check({tag, "/code"}, 32'(err_code), 32'(code));
        wait_idle(tag);
        if (code != 0) ref_err();
        else ref_apply(int'(cmd), int'(idx), (cmd == 8'h03) ? 24'd0 : rgb);
        check({tag, "/n_wr"}, 32'(n_wr - w0), 32'(exp_wr));
        check({tag, "/n_err"}, 32'(n_err - e0), 32'(code != 0));
        check({tag, "/n_ok"}, 32'(n_ok - k0), 32'(code == 0));
        check({tag, "/err_cnt"}, 32'(err_cnt), 32'(ref_cnt));
        mem_check(tag);
    endtask

    initial begin
        int seq_bad;
        int w0;
        int e0;

        // Reset state
        tick();
        tick();
        check("rst/wr_en", 32'(wr_en), 32'd0);
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/frame_ok", 32'(frame_ok), 32'd0);
        check("rst/err", 32'(err), 32'd0);
        check("rst/err_code", 32'(err_code), 32'd0);
        check("rst/err_cnt", 32'(err_cnt), 32'd0);
        check("rst/wr_addr", 32'(wr_addr), 32'd0);
        check("rst/wr_rgb", 32'(wr_rgb), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single WRITE with exact pulse timing
        build(8'h01, 8'h03, 8'hFF, 8'h80, 8'h00, 8'h00);
        send_frame();
        check("write/wr_en", 32'(wr_en), 32'd1);
        check("write/addr", 32'(wr_addr), 32'd3);
        check("write/rgb", 32'(wr_rgb), 32'hFF8000);
        check("write/ok", 32'(frame_ok), 32'd1);
        check("write/err", 32'(err), 32'd0);
        tick();
        check("write/wr_en_low", 32'(wr_en), 32'd0);
        check("write/addr_hold", 32'(wr_addr), 32'd3);
        check("write/ok_low", 32'(frame_ok), 32'd0);
        ref_mem[3] = 24'hFF8000;
        mem_check("write");

        // FILL sweep: N consecutive writes, addresses in order
        build(8'h02, 8'h00, 8'h10, 8'h20, 8'h30, 8'h00);
        send_frame();
        check("fill/ok", 32'(frame_ok), 32'd1);
        seq_bad = 0;
        for (int i = 0; i < int'(N); i++) begin
            if (!(wr_en === 1'b1 && busy === 1'b1 && wr_addr === AW'(i) && wr_rgb === 24'h102030))
                seq_bad++;
            tick();
        end
        check("fill/seq", 32'(seq_bad), 32'd0);
        check("fill/busy_low", 32'(busy), 32'd0);
        check("fill/wr_en_low", 32'(wr_en), 32'd0);
        check("fill/addr_hold", 32'(wr_addr), 32'(N - 1));
        ref_apply(2, 0, 24'h102030);
        tick();
        mem_check("fill");

`ifdef LED_CMD_CHECKSUM_EN
        // Bad checksum, then a good frame is still accepted
        run_and_check("badchk", 8'h01, 8'h03, 24'hFF8000, 8'hFF);
        check("badchk/cnt1", 32'(err_cnt), 32'd1);
`endif
        run_and_check("after_err", 8'h01, 8'h05, 24'h123456, 8'h00);

        // Index out of range and unknown command
        run_and_check("badidx", 8'h01, 8'h14, 24'h000000, 8'h00);
        run_and_check("idx_edge", 8'h01, 8'(N - 1), 24'hABCDEF, 8'h00);
        run_and_check("idx_over", 8'h01, 8'(N), 24'hABCDEF, 8'h00);
        run_and_check("badcmd", 8'h07, 8'h00, 24'h010203, 8'h00);

        // Timeout on a partial frame at the exact cycle
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (int'(TO) - 1) tick();
        check("timeout/early", 32'(err), 32'd0);
        tick();
        check("timeout/err", 32'(err), 32'd1);
        check("timeout/code", 32'(err_code), 32'd4);
        ref_err();
        check("timeout/cnt", 32'(err_cnt), 32'(ref_cnt));
        tick();
        check("timeout/pulse", 32'(err), 32'd0);
        run_and_check("after_to", 8'h01, 8'h07, 24'h0F0F0F, 8'h00);

        // Overrun during FILL: byte dropped, sweep completes, SYNC required afterwards
        w0 = n_wr;
        build(8'h02, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h00);
        send_frame();
        tick();
        tick();
        send_byte(8'h55);
        check("ovr/err", 32'(err), 32'd1);
        check("ovr/code", 32'(err_code), 32'd5);
        check("ovr/busy", 32'(busy), 32'd1);
        ref_err();
        wait_idle("ovr");
        check("ovr/n_wr", 32'(n_wr - w0), 32'(N));
        check("ovr/cnt", 32'(err_cnt), 32'(ref_cnt));
        ref_apply(2, 0, 24'h0A0B0C);
        mem_check("ovr");
        w0 = n_wr;
        e0 = n_err;
        build(8'h01, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int i = 1; i < frame.size(); i++) send_byte(frame[i]);
        tick();
        check("nosync/n_wr", 32'(n_wr - w0), 32'd0);
        check("nosync/n_err", 32'(n_err - e0), 32'd0);

        // Random frames against the model
        for (int t = 0; t < 40; t++) begin
            logic [7:0]  cmd;
            logic [7:0]  noise;
            logic [7:0]  flip;
            int          sel;
            sel = int'($urandom_range(0, 4));
            cmd = (sel <= 1) ? 8'h01 : (sel == 4) ? 8'($urandom_range(0, 255)) : 8'(sel);
            flip = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            if ($urandom_range(0, 2) == 0) begin
                noise = 8'($urandom_range(0, 255));
                if (noise == 8'hA5) noise = 8'h00;
                send_byte(noise);
            end
            run_and_check($sformatf("rnd%0d", t), cmd, 8'($urandom_range(0, 23)),
                          24'($urandom), flip);
        end

        // Error counter saturation
        e0 = n_err;
        for (int i = 0; i < 300; i++) begin
`ifdef LED_CMD_CHECKSUM_EN
            build(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h01);
`else
            build(8'h09, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00);
`endif
            send_frame();
            ref_err();
        end
        tick();
        check("sat/n_err", 32'(n_err - e0), 32'd300);
        check("sat/cnt", 32'(err_cnt), 32'd255);

        // Reset in the middle of a sweep
        build(8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00);
        send_frame();
        repeat (4) tick();
        check("rstsw/busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check("rstsw/wr_en", 32'(wr_en), 32'd0);
        check("rstsw/busy", 32'(busy), 32'd0);
        check("rstsw/cnt", 32'(err_cnt), 32'd0);
        check("rstsw/ok", 32'(frame_ok), 32'd0);
        rst_n = 1'b1;
        ref_cnt = 0;
        tick();
        check("rstsw/busy_after", 32'(busy), 32'd0);
        run_and_check("clear", 8'h03, 8'h44, 24'h556677, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_cmd_decoder.md
# led_cmd_decoder

Byte-stream command decoder directly downstream of the SPI slave receiver in the spi-led design. Consumes one received byte per valid pulse, frames fixed-length LED commands, checks them, and issues write strobes into the LED colour buffer that feeds the LED output driver. Malformed, stalled or overrunning frames are reported on an error strobe and a saturating counter.

## Interface
- NUM_LEDS, 16, number of addressable LEDs; legal range 2..256
- IDX_W, $clog2(NUM_LEDS), width of LED address output
- TIMEOUT_CYC, 24'd1_000_000, i_clk cycles without a byte before a partial frame is discarded
---
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_rx_data  in  8  received byte, sampled only when i_rx_valid=1
- i_rx_valid  in  1  one-cycle strobe per received byte
- o_wr_en  out  1  LED buffer write strobe
- o_wr_addr  out  IDX_W  LED index for write
- o_wr_rgb  out  24  {R,G,B} for write
- o_busy  out  1  high while a fill/clear sweep is running
- o_frame_ok  out  1  one-cycle pulse per accepted frame
- o_err  out  1  one-cycle pulse per rejected frame/byte
- o_err_code  out  3  error cause, valid with o_err
- o_err_cnt  out  8  saturating count of o_err pulses

## Operation
- Frame: SYNC(0xA5), CMD, IDX, R, G, B, CHK; CHK = CMD^IDX^R^G^B.
- CMD 0x01 WRITE: one write of {R,G,B} to IDX. CMD 0x02 FILL: write {R,G,B} to all LEDs, IDX ignored. CMD 0x03 CLEAR: write 0 to all LEDs, IDX/R/G/B ignored.
- States: IDLE, GET_CMD, GET_IDX, GET_R, GET_G, GET_B, GET_CHK, SWEEP. Each valid byte advances one state; IDLE advances only on 0xA5, other bytes silently dropped (no error).
- After final byte: CHK mismatch → err BADCHK(1); CMD not in {1,2,3} → BADCMD(2); WRITE with IDX ≥ NUM_LEDS → BADIDX(3). Checks in that priority; one err per frame; no write; return IDLE.
- Timeout: in any GET_* state, TIMEOUT_CYC consecutive cycles without i_rx_valid → err TIMEOUT(4), return IDLE. Counter reset by every valid byte.
- Overrun: i_rx_valid during SWEEP → byte dropped, err OVERRUN(5); sweep continues; decoder returns to IDLE after sweep (next frame must resend SYNC).
- o_err_cnt increments per o_err, holds at 255.
- Reset (any time, including mid-sweep): all outputs 0, state IDLE, o_err_cnt=0, timeout counter 0; a partial sweep is abandoned.

## Timing
- WRITE: o_wr_en high exactly one cycle, cycle after the valid of last frame byte; o_frame_ok pulses same cycle.
- FILL/CLEAR: o_busy and o_wr_en high for NUM_LEDS consecutive cycles starting cycle after last byte; o_wr_addr 0,1,…,NUM_LEDS-1; o_frame_ok with first write; o_busy low cycle after last write.
- Error pulses: cycle after the offending valid (BADCHK/BADCMD/BADIDX/OVERRUN) or cycle after counter reaches TIMEOUT_CYC.
- o_wr_addr/o_wr_rgb registered; hold last value when o_wr_en=0.
- Back-to-back valid bytes on consecutive cycles accepted outside SWEEP.

## Configuration
- LED_CMD_CHECKSUM_EN defined: 7-byte frame with CHK, BADCHK checked.
- Undefined: 6-byte frame, GET_CHK state absent, frame completes on B byte, BADCHK never reported; all timing relative to B byte.

## Structure
- led_cmd_pkg: SYNC_BYTE, CMD_WRITE/FILL/CLEAR constants, err_code_e enum (NONE=0..OVERRUN=5), state_e enum.
- Sub-module led_sweep_gen: address counter 0..NUM_LEDS-1 with start/busy/done, instantiated once for SWEEP.

## Test plan
- A5 01 03 FF 80 00 7D → one write addr 3 rgb 0xFF8000, o_frame_ok, no err.
- A5 02 00 10 20 30 02 → 16 writes addr 0..15 rgb 0x102030, o_busy 16 cycles.
- A5 01 03 FF 80 00 00 → o_err code 1, no write, o_err_cnt=1; then valid frame accepted.
- A5 01 14 00 00 00 15 (IDX 20) → err 3; A5 07 … valid CHK → err 2.
- A5 01 then 1,000,000 idle cycles → err 4 at exact cycle; byte 0x55 during FILL sweep → err 5, sweep completes all 16 writes.
- 300 bad-checksum frames → o_err_cnt saturates at 255; reset mid-sweep → o_wr_en, o_busy drop next cycle, counter 0.
